// File: rtl/clk_div_mon.sv
// Receiving-end checker for a divide-by-2N waveform: measures high/low phase lengths,
// declares lock after LOCK_CNT good periods, flags duty and stuck faults. Macro: CLK_MON_SYNC_EN.
module clk_div_mon #(
  parameter int unsigned N         = 4,
  parameter int unsigned CW        = 8,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned STUCK_MAX = 16
) (
  input  logic          i_clk,
  input  logic          rst,
  input  logic          div_in,
  input  logic          err_clr,
  output logic [CW-1:0] high_len,
  output logic [CW-1:0] low_len,
  output logic [CW:0]   period,
  output logic          period_vld,
  output logic          locked,
  output logic          duty_err,
  output logic          stuck,
  output logic          err_sticky
);
  localparam int unsigned   GW      = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] STUCK_C = CW'(STUCK_MAX);
  localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

  state_t        r_state;
  logic          r_s_d;
  logic          r_have_high;
  logic          r_have_low;
  logic [CW-1:0] r_run;
  logic [GW-1:0] r_good_cnt;

  logic          w_s;
  logic          w_rise;
  logic          w_fall;
  logic          w_edge;
  logic          w_good;
  logic          w_period_evt;
  logic          w_stuck_evt;
  logic          w_err_evt;
  logic [CW-1:0] w_run_inc;

`ifdef CLK_MON_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= div_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = div_in;
`endif

  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_edge    = w_rise | w_fall;
  assign w_run_inc = (r_run == '1) ? r_run : r_run + CW'(1);
  // A period is reported only once both phases were already seen before this rising
  // edge, so a phase truncated by reset or acquisition never gets judged.
  assign w_period_evt = w_rise & r_have_high & r_have_low;
  assign w_good       = (high_len == N_C) && (r_run == N_C);
  assign w_stuck_evt  = (r_state != ACQ) && !w_edge && (r_run == STUCK_C);
  assign w_err_evt    = w_stuck_evt | (w_period_evt & ~w_good);

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACQ;
      r_s_d       <= 1'b0;
      r_run       <= '0;
      r_have_high <= 1'b0;
      r_have_low  <= 1'b0;
      r_good_cnt  <= '0;
      high_len    <= '0;
      low_len     <= '0;
      period      <= '0;
      period_vld  <= 1'b0;
      locked      <= 1'b0;
      duty_err    <= 1'b0;
      stuck       <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      r_s_d      <= w_s;
      period_vld <= 1'b0;
      duty_err   <= 1'b0;
      stuck      <= 1'b0;

      if (w_err_evt) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end

      case (r_state)
        ACQ: begin
          if (w_edge) begin
            r_state <= TRACK;
            r_run   <= CW'(1);
          end
        end
        default: begin
          if (w_stuck_evt) begin
            stuck       <= 1'b1;
            r_state     <= ACQ;
            r_run       <= '0;
            r_have_high <= 1'b0;
            r_have_low  <= 1'b0;
            r_good_cnt  <= '0;
            locked      <= 1'b0;
          end else begin
            r_run <= w_edge ? CW'(1) : w_run_inc;
            if (w_fall) begin
              high_len    <= r_run;
              r_have_high <= 1'b1;
            end
            if (w_rise) begin
              low_len    <= r_run;
              r_have_low <= 1'b1;
            end
            if (w_period_evt) begin
              period_vld <= 1'b1;
              period     <= {1'b0, high_len} + {1'b0, r_run};
              if (w_good) begin
                if (r_state == TRACK) begin
                  r_good_cnt <= r_good_cnt + GW'(1);
                  if (r_good_cnt + GW'(1) == LOCK_C) begin
                    r_state <= LOCKED;
                    locked  <= 1'b1;
                  end
                end
              end else begin
                duty_err   <= 1'b1;
                r_good_cnt <= '0;
                r_state    <= TRACK;
                locked     <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_div_mon.sv
// Self-checking bench for clk_div_mon: vector table of waveform segments, hand-written
// lock/stuck/reset sequences, and random waveforms against a timestamp-based reference model.
module tb_clk_div_mon;
  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int LOCK  = 3;
  localparam int STUCK = 16;
`ifdef CLK_MON_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          rst = 1'b0;
  logic          div_in = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] high_len;
  logic [CW-1:0] low_len;
  logic [CW:0]   period;
  logic          period_vld;
  logic          locked;
  logic          duty_err;
  logic          stuck;
  logic          err_sticky;

  clk_div_mon #(.N(N), .CW(CW), .LOCK_CNT(LOCK), .STUCK_MAX(STUCK)) dut (
    .i_clk(i_clk), .rst(rst), .div_in(div_in), .err_clr(err_clr),
    .high_len(high_len), .low_len(low_len), .period(period),
    .period_vld(period_vld), .locked(locked), .duty_err(duty_err),
    .stuck(stuck), .err_sticky(err_sticky)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase lengths are differences between edge timestamps.
  int m_cyc, m_last, m_hi, m_lo, m_period, m_good;
  bit m_acq, m_hh, m_hl, m_locked, m_vld, m_duty, m_stuck, m_sticky;
  bit m_prev, m_s1, m_s2;

  // Observation counters
  int t_cyc, cnt_vld, cnt_duty, cnt_stuck, lock_at, drop_vld, drops;
  int last_vld_cyc, stuck_cyc, exp_int, bad_int;
  logic prev_locked;

  typedef struct {
    int hi; int lo; int reps;
    int exp_vld; int exp_duty; int exp_locked; int exp_lock_at; int exp_period; int exp_sticky;
  } seg_t;
  seg_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] dut_vec();
    return {high_len, low_len, period, period_vld, locked, duty_err, stuck, err_sticky};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {8'(m_hi), 8'(m_lo), 9'(m_period), m_vld, m_locked, m_duty, m_stuck, m_sticky};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_last = 0; m_hi = 0; m_lo = 0; m_period = 0; m_good = 0;
    m_acq = 1; m_hh = 0; m_hl = 0; m_locked = 0; m_vld = 0; m_duty = 0;
    m_stuck = 0; m_sticky = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step(input bit d, input bit c);
    bit s, edge_seen, rise, both;
    int len;
    s = SYNC ? m_s2 : d;
    m_s2 = m_s1;
    m_s1 = d;
    m_cyc++;
    edge_seen = (s != m_prev);
    rise = edge_seen && s;
    len = m_cyc - m_last;
    m_vld = 0; m_duty = 0; m_stuck = 0;
    if (m_acq) begin
      if (edge_seen) begin
        m_acq = 0;
        m_last = m_cyc;
      end
    end else if (!edge_seen && len == STUCK) begin
      m_stuck = 1; m_acq = 1; m_hh = 0; m_hl = 0; m_good = 0; m_locked = 0;
    end else if (edge_seen) begin
      if (!rise) begin
        m_hi = len; m_hh = 1;
      end else begin
        both = m_hh && m_hl;
        m_lo = len; m_hl = 1;
        if (both) begin
          m_vld = 1;
          m_period = m_hi + m_lo;
          if (m_hi == N && m_lo == N) begin
            if (!m_locked) begin
              m_good++;
              if (m_good == LOCK) m_locked = 1;
            end
          end else begin
            m_duty = 1; m_good = 0; m_locked = 0;
          end
        end
      end
      m_last = m_cyc;
    end
    m_prev = s;
    if (m_stuck || m_duty) m_sticky = 1;
    else if (c) m_sticky = 0;
  endtask

  task automatic mon_reset();
    t_cyc = 0; cnt_vld = 0; cnt_duty = 0; cnt_stuck = 0; lock_at = 0; drop_vld = 0;
    drops = 0; last_vld_cyc = 0; stuck_cyc = 0; bad_int = 0; prev_locked = 0;
  endtask

  task automatic monitor();
    t_cyc++;
    if (period_vld) begin
      if (cnt_vld > 0 && (t_cyc - last_vld_cyc) != exp_int) bad_int++;
      cnt_vld++;
      last_vld_cyc = t_cyc;
    end
    if (duty_err) cnt_duty++;
    if (stuck) begin
      cnt_stuck++;
      stuck_cyc = t_cyc;
    end
    if (locked && !prev_locked) lock_at = cnt_vld;
    if (!locked && prev_locked) begin
      drops++;
      drop_vld = cnt_vld;
    end
    prev_locked = locked;
  endtask

  task automatic step(input logic d, input logic c);
    div_in = d;
    err_clr = c;
    @(posedge i_clk);
    model_step(d, c);
    #1;
    chk("cycle_outputs", int'(dut_vec()), int'(exp_vec()));
    monitor();
  endtask

  task automatic phase(input int hi, input int lo, input bit rclr);
    repeat (hi) step(1'b1, rclr && ($urandom_range(0, 7) == 0));
    repeat (lo) step(1'b0, rclr && ($urandom_range(0, 7) == 0));
  endtask

  task automatic do_reset(input logic d);
    div_in = d;
    err_clr = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_outputs", int'(dut_vec()), 0);
    model_reset();
    mon_reset();
    repeat (2) @(posedge i_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sel, h, l;
    tbl[0] = '{4, 4, 6, 5, 0, 1, 3, 8, 0};
    tbl[1] = '{3, 5, 6, 5, 5, 0, 0, 8, 1};
    tbl[2] = '{5, 4, 4, 3, 3, 0, 0, 9, 1};
    tbl[3] = '{4, 4, 3, 2, 0, 0, 0, 8, 0};
    tbl[4] = '{2, 6, 3, 2, 2, 0, 0, 8, 1};
    exp_int = 0;
    #2;

    for (int i = 0; i < 5; i++) begin
      do_reset(1'b0);
      exp_int = tbl[i].hi + tbl[i].lo;
      repeat (3) step(1'b0, 1'b0);
      repeat (tbl[i].reps) phase(tbl[i].hi, tbl[i].lo, 1'b0);
      repeat (4) step(1'b1, 1'b0);
      chk("tbl_vld_count", cnt_vld, tbl[i].exp_vld);
      chk("tbl_duty_count", cnt_duty, tbl[i].exp_duty);
      chk("tbl_locked", int'(locked), tbl[i].exp_locked);
      chk("tbl_lock_at_vld", lock_at, tbl[i].exp_lock_at);
      chk("tbl_period", int'(period), tbl[i].exp_period);
      chk("tbl_sticky", int'(err_sticky), tbl[i].exp_sticky);
      chk("tbl_vld_spacing", bad_int, 0);
    end

    // Lock, one 5/4 period, then relock after three good periods.
    do_reset(1'b0);
    exp_int = 8;
    repeat (3) step(1'b0, 1'b0);
    repeat (5) phase(4, 4, 1'b0);
    chk("A_locked_first", int'(locked), 1);
    phase(5, 4, 1'b0);
    repeat (3) phase(4, 4, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    chk("A_duty_count", cnt_duty, 1);
    chk("A_lock_drops", drops, 1);
    chk("A_relocked", int'(locked), 1);
    chk("A_relock_periods", lock_at - drop_vld, 3);

    // Hold high while locked until the stuck timeout fires.
    k = 0;
    while (cnt_stuck == 0 && k < 40) begin
      step(1'b1, 1'b0);
      k++;
    end
    chk("B_stuck_count", cnt_stuck, 1);
    chk("B_stuck_delay", stuck_cyc - last_vld_cyc, 16);
    chk("B_locked_after_stuck", int'(locked), 0);
    chk("B_sticky_set", int'(err_sticky), 1);
    step(1'b1, 1'b1);
    chk("B_sticky_cleared", int'(err_sticky), 0);

    // Reset mid-high while locked.
    do_reset(1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (5) phase(4, 4, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    chk("C_locked_pre", int'(locked), 1);
    do_reset(1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    repeat (2) phase(4, 4, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    chk("C_vld_count", cnt_vld, 2);
    chk("C_duty_count", cnt_duty, 0);
    chk("C_locked_post", int'(locked), 0);

    // Random waveforms with random err_clr, checked cycle by cycle against the model.
    do_reset(1'b0);
    for (int p = 0; p < 60; p++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        h = 4; l = 4;
      end else if (sel < 8) begin
        h = int'($urandom_range(1, 8)); l = int'($urandom_range(1, 8));
      end else if (sel == 8) begin
        h = int'($urandom_range(10, 20)); l = 4;
      end else begin
        h = 4; l = int'($urandom_range(10, 20));
      end
      phase(h, l, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
